// File: rtl/pipeline_run_ctrl_if.sv
// Command, handshake and status bundle between the debug unit and the run/step sequencer.
interface pipeline_run_ctrl_if #(
  parameter int CW = 32
);
  logic          cmd_valid;
  logic [1:0]    cmd;
  logic          cmd_ready;
  logic          final_wb;
  logic          dump_ack;
  logic          pipe_en;
  logic          inicio;
  logic          pc_reset;
  logic          dump_req;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;

  modport master (
    output cmd_valid, cmd, final_wb, dump_ack,
    input  cmd_ready, pipe_en, inicio, pc_reset, dump_req, busy, done, timeout, cycle_count
  );

  modport slave (
    input  cmd_valid, cmd, final_wb, dump_ack,
    output cmd_ready, pipe_en, inicio, pc_reset, dump_req, busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Run/step sequencer for the debug MIPS pipeline: flushes after start, runs or single-steps,
// freezes on END in write-back, ABORT or timeout, and requests a state dump after each step/halt.
module pipeline_run_ctrl #(
  parameter int CW          = 32,
  parameter int INIT_CYCLES = 5,
  parameter int MAX_CYCLES  = 2**20
) (
  input logic                clk,
  input logic                reset,
  pipeline_run_ctrl_if.slave bus
);
  localparam int IW = $clog2(INIT_CYCLES) + 1;
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_CYCLES);
  localparam logic [IW-1:0] INIT_END = IW'(INIT_CYCLES - 1);

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  typedef enum logic [2:0] {
    IDLE, INIT, RUN, STEP, DUMP, STEP_WAIT, HALTED
  } state_t;

  state_t        state;
  logic          mode_step;
  logic          halt;
  logic          timeout_q;
  logic [CW-1:0] cnt;
  logic [IW-1:0] init_cnt;

  logic cmd_ready, accept, run_acc, step_acc, abort_acc, pipe_en;

  always_comb begin
    cmd_ready = (state == IDLE) || (state == RUN) || (state == STEP_WAIT) || (state == HALTED);
    accept    = bus.cmd_valid && cmd_ready;
    run_acc   = accept && (bus.cmd == CMD_RUN);
    step_acc  = accept && (bus.cmd == CMD_STEP);
    abort_acc = accept && (bus.cmd == CMD_ABORT);
    pipe_en   = 1'b0;
    case (state)
      INIT:    pipe_en = 1'b1;
      STEP:    pipe_en = 1'b1;
      // ABORT and END freeze the pipeline in the very cycle they are seen
      RUN:     pipe_en = !bus.final_wb && !abort_acc && (cnt != MAX_C);
      default: pipe_en = 1'b0;
    endcase
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.pipe_en     = pipe_en;
  assign bus.inicio      = (state == IDLE) || (state == INIT);
  assign bus.pc_reset    = (state == IDLE) || (state == INIT);
  assign bus.dump_req    = (state == DUMP);
  assign bus.busy        = (state != IDLE) && (state != HALTED);
  assign bus.done        = (state == HALTED);
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mode_step <= 1'b0;
      halt      <= 1'b0;
      timeout_q <= 1'b0;
      cnt       <= '0;
      init_cnt  <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (run_acc || step_acc) begin
            state     <= INIT;
            mode_step <= step_acc;
            halt      <= 1'b0;
            timeout_q <= 1'b0;
            cnt       <= '0;
            init_cnt  <= '0;
          end else if (abort_acc && state == HALTED) begin
            state <= IDLE;
          end
        end
        INIT: begin
          if (init_cnt == INIT_END) begin
            state <= mode_step ? STEP : RUN;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: begin
          if (pipe_en) begin
            cnt <= cnt + 1'b1;
          end
          if (bus.final_wb || abort_acc) begin
            state <= DUMP;
            halt  <= 1'b1;
          end else if (cnt == MAX_C) begin
            state     <= DUMP;
            halt      <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        STEP: begin
          cnt   <= cnt + 1'b1;
          state <= DUMP;
        end
        DUMP: begin
          halt <= halt | bus.final_wb;
          if (bus.dump_ack) begin
            state <= (halt || bus.final_wb) ? HALTED : STEP_WAIT;
          end
        end
        STEP_WAIT: begin
          if (step_acc) begin
            state <= STEP;
          end else if (run_acc) begin
            state     <= RUN;
            mode_step <= 1'b0;
          end else if (abort_acc) begin
            state <= HALTED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: per-cycle vector table plus multi-cycle run/step/abort/reset sequences.
module tb_pipeline_run_ctrl;
  localparam logic [1:0] NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, ABORT = 2'b11;

  typedef struct packed {
    logic        cv;
    logic [1:0]  cmd;
    logic        fwb;
    logic        ack;
    logic [7:0]  exp_o;   // pipe_en inicio pc_reset dump_req cmd_ready busy done timeout
    logic [31:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fwb_tbl = 1'b0;
  logic end_en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  vec_t tbl[19];

  always #5 clk = ~clk;

  pipeline_run_ctrl_if #(.CW(32)) bus ();

  pipeline_run_ctrl #(.CW(32), .INIT_CYCLES(5), .MAX_CYCLES(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Program model: END reaches write-back once 14 instructions have been clocked through
  assign bus.final_wb = fwb_tbl | (end_en && (bus.cycle_count >= 32'd14));

  function automatic logic [7:0] outs();
    return {bus.pipe_en, bus.inicio, bus.pc_reset, bus.dump_req,
            bus.cmd_ready, bus.busy, bus.done, bus.timeout};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = NOP;
    #1;
  endtask

  task automatic ack();
    bus.dump_ack = 1'b1;
    @(negedge clk);
    bus.dump_ack = 1'b0;
    #1;
  endtask

  task automatic wait_dump(input int bound, output int init_n, output int run_n,
                           output int rdy_hi, output bit seen);
    init_n = 0; run_n = 0; rdy_hi = 0; seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (bus.dump_req) begin
        seen = 1'b1;
        break;
      end
      if (bus.pipe_en && bus.inicio)  init_n++;
      if (bus.pipe_en && !bus.inicio) run_n++;
      if (bus.cmd_ready)              rdy_hi++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_count(input logic [31:0] n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.cycle_count == n && !bus.inicio) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int  init_n, run_n, rdy_hi;
    bit  seen;

    bus.cmd_valid = 1'b0;
    bus.cmd       = NOP;
    bus.dump_ack  = 1'b0;

    tbl[0]  = '{1'b1, STEP,  1'b0, 1'b0, 8'b0110_1000, 32'd0};
    tbl[1]  = '{1'b1, RUN,   1'b0, 1'b0, 8'b1110_0100, 32'd0};
    tbl[2]  = '{1'b0, NOP,   1'b0, 1'b0, 8'b1110_0100, 32'd0};
    tbl[3]  = '{1'b0, NOP,   1'b0, 1'b0, 8'b1110_0100, 32'd0};
    tbl[4]  = '{1'b0, NOP,   1'b0, 1'b0, 8'b1110_0100, 32'd0};
    tbl[5]  = '{1'b0, NOP,   1'b0, 1'b0, 8'b1110_0100, 32'd0};
    tbl[6]  = '{1'b0, NOP,   1'b0, 1'b0, 8'b1000_0100, 32'd0};
    tbl[7]  = '{1'b0, NOP,   1'b0, 1'b0, 8'b0001_0100, 32'd1};
    tbl[8]  = '{1'b0, NOP,   1'b0, 1'b1, 8'b0001_0100, 32'd1};
    tbl[9]  = '{1'b1, STEP,  1'b0, 1'b0, 8'b0000_1100, 32'd1};
    tbl[10] = '{1'b0, NOP,   1'b0, 1'b0, 8'b1000_0100, 32'd1};
    tbl[11] = '{1'b0, NOP,   1'b0, 1'b1, 8'b0001_0100, 32'd2};
    tbl[12] = '{1'b1, RUN,   1'b0, 1'b0, 8'b0000_1100, 32'd2};
    tbl[13] = '{1'b0, NOP,   1'b0, 1'b1, 8'b1000_1100, 32'd2};
    tbl[14] = '{1'b1, ABORT, 1'b0, 1'b0, 8'b0000_1100, 32'd3};
    tbl[15] = '{1'b0, NOP,   1'b0, 1'b1, 8'b0001_0100, 32'd3};
    tbl[16] = '{1'b1, ABORT, 1'b0, 1'b0, 8'b0000_1010, 32'd3};
    tbl[17] = '{1'b1, ABORT, 1'b0, 1'b0, 8'b0110_1000, 32'd3};
    tbl[18] = '{1'b0, NOP,   1'b0, 1'b0, 8'b0110_1000, 32'd3};

    // Reset state
    #2;
    chk("reset_outs", 64'(outs()), 64'(8'b0110_1000));
    chk("reset_cnt", 64'(bus.cycle_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Per-cycle vectors: step flow, RUN from STEP_WAIT, ABORT paths, ignored commands/acks
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      bus.cmd_valid = tbl[i].cv;
      bus.cmd       = tbl[i].cmd;
      fwb_tbl       = tbl[i].fwb;
      bus.dump_ack  = tbl[i].ack;
      #1;
      chk($sformatf("vec%0d_outs", i), 64'(outs()), 64'(tbl[i].exp_o));
      chk($sformatf("vec%0d_cnt", i), 64'(bus.cycle_count), 64'(tbl[i].exp_cnt));
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = NOP;
    bus.dump_ack  = 1'b0;
    fwb_tbl       = 1'b0;
    #1;

    // RUN to END in write-back
    end_en = 1'b1;
    issue(RUN);
    wait_dump(300, init_n, run_n, rdy_hi, seen);
    chk("run_dump_seen", 64'(seen), 64'd1);
    chk("run_init_cycles", 64'(init_n), 64'd5);
    chk("run_en_cycles", 64'(run_n), 64'd14);
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    chk("run_dump_held", 64'({bus.dump_req, bus.pipe_en}), 64'(2'b10));
    ack();
    chk("run_halt", 64'({bus.done, bus.dump_req, bus.timeout}), 64'(3'b100));
    chk("run_cnt", 64'(bus.cycle_count), 64'd14);

    // Three single steps, the first one through INIT
    for (int s = 1; s <= 3; s++) begin
      issue(STEP);
      wait_dump(50, init_n, run_n, rdy_hi, seen);
      chk($sformatf("step%0d_seen", s), 64'(seen), 64'd1);
      chk($sformatf("step%0d_en", s), 64'(run_n), 64'd1);
      chk($sformatf("step%0d_rdy_lo", s), 64'(rdy_hi + (bus.cmd_ready ? 1 : 0)), 64'd0);
      ack();
      chk($sformatf("step%0d_cnt", s), 64'(bus.cycle_count), 64'(s));
      chk($sformatf("step%0d_wait", s), 64'({bus.cmd_ready, bus.busy, bus.done}), 64'(3'b110));
    end

    // RUN from STEP_WAIT continues without re-INIT
    issue(RUN);
    wait_dump(100, init_n, run_n, rdy_hi, seen);
    chk("cont_seen", 64'(seen), 64'd1);
    chk("cont_init", 64'(init_n), 64'd0);
    chk("cont_en", 64'(run_n), 64'd11);
    ack();
    chk("cont_halt", 64'({bus.done, bus.timeout}), 64'(2'b10));
    chk("cont_cnt", 64'(bus.cycle_count), 64'd14);

    // Infinite loop hits the cycle limit
    end_en = 1'b0;
    issue(RUN);
    wait_dump(400, init_n, run_n, rdy_hi, seen);
    chk("to_seen", 64'(seen), 64'd1);
    chk("to_en", 64'(run_n), 64'd100);
    ack();
    chk("to_halt", 64'({bus.done, bus.timeout}), 64'(2'b11));
    chk("to_cnt", 64'(bus.cycle_count), 64'd100);

    // ABORT in RUN at cycle 7, then ABORT from HALTED
    issue(RUN);
    wait_count(32'd7, seen);
    chk("abort_reach7", 64'(seen), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd       = ABORT;
    #1;
    chk("abort_pe_same_cycle", 64'(bus.pipe_en), 64'd0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = NOP;
    #1;
    chk("abort_dump", 64'({bus.dump_req, bus.pipe_en}), 64'(2'b10));
    ack();
    chk("abort_halt", 64'({bus.done, bus.timeout}), 64'(2'b10));
    chk("abort_cnt", 64'(bus.cycle_count), 64'd7);
    issue(ABORT);
    chk("abort_idle", 64'(outs()), 64'(8'b0110_1000));

    // Reset while a dump is pending
    issue(RUN);
    wait_count(32'd3, seen);
    bus.cmd_valid = 1'b1;
    bus.cmd       = ABORT;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = NOP;
    #1;
    chk("rst_pre_dump", 64'(bus.dump_req), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_async", 64'({bus.dump_req, bus.pipe_en, bus.inicio}), 64'(3'b001));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_after_outs", 64'(outs()), 64'(8'b0110_1000));
    chk("rst_after_cnt", 64'(bus.cycle_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
